// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared constants, types and keep/CRC helpers for the RX CRC-32 checker
package crc_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CRC_WIDTH  = 32;
    localparam logic [CRC_WIDTH-1:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [CRC_WIDTH-1:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [CRC_WIDTH-1:0] CRC_POLY_REFL = 32'hEDB88320;

    typedef logic [CRC_WIDTH-1:0] crc_table_t [256];

    typedef enum logic {RX_EMPTY, RX_HELD} rx_state_t;

    // One entry of the reflected byte table (0x04C11DB7 bit-reversed)
    function automatic logic [CRC_WIDTH-1:0] crc32_table_entry(input logic [7:0] idx);
        logic [CRC_WIDTH-1:0] c;
        c = {24'd0, idx};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [2:0] keep_popcount(input logic [3:0] keep);
        return {2'b00, keep[0]} + {2'b00, keep[1]} + {2'b00, keep[2]} + {2'b00, keep[3]};
    endfunction

    function automatic logic keep_is_contiguous(input logic [3:0] keep);
        return (keep == 4'b0001) || (keep == 4'b0011) || (keep == 4'b0111) || (keep == 4'b1111);
    endfunction

    function automatic logic [3:0] keep_lower_mask(input logic [2:0] k);
        logic [4:0] m;
        m = (5'd1 << k) - 5'd1;
        return m[3:0];
    endfunction

endpackage

// File: rtl/rx_crc32_step.sv
// rtl/rx_crc32_step.sv - combinational byte-sliced CRC-32 update over keep-enabled bytes
module rx_crc32_step
    import crc_pkg::*;
(
    input  logic [CRC_WIDTH-1:0]  seed,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [3:0]            keep,
    output logic [CRC_WIDTH-1:0]  crc_next
);

    crc_table_t table0;

    for (genvar i = 0; i < 256; i++) begin : g_table
        assign table0[i] = crc32_table_entry(8'(i));
    end

    // Byte 0 is first on the wire, so it is folded in first
    always_comb begin
        logic [CRC_WIDTH-1:0] c;
        c = seed;
        for (int b = 0; b < 4; b++) begin
            if (keep[b]) begin
                c = (c >> 8) ^ table0[c[7:0] ^ data[8*b +: 8]];
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/rx_crc32_checker.sv
// rtl/rx_crc32_checker.sv - RX FCS checker: one-word hold strips the FCS and flags good/bad frames
module rx_crc32_checker
    import crc_pkg::*;
(
    input  logic                  clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [3:0]            i_data_keep,
    input  logic                  i_data_valid,
    input  logic                  i_data_last,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [3:0]            o_data_keep,
    output logic                  o_data_valid,
    output logic                  o_data_last,
    output logic                  o_status_valid,
    output logic                  o_crc_err
);

    rx_state_t             state;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [CRC_WIDTH-1:0]  crc_reg;
    logic [CRC_WIDTH-1:0]  crc_seed;
    logic [CRC_WIDTH-1:0]  crc_next;
    logic                  err_sticky;
    logic [3:0]            last_keep;
    logic [DATA_WIDTH-1:0] last_mask;
    logic                  last_keep_bad;
    logic                  mid_keep_bad;

    assign crc_seed      = (state == RX_EMPTY) ? CRC_INIT : crc_reg;
    assign last_keep     = keep_lower_mask(keep_popcount(i_data_keep));
    assign last_keep_bad = !keep_is_contiguous(i_data_keep);
    assign mid_keep_bad  = (i_data_keep != 4'hF);

    always_comb begin
        last_mask = '0;
        for (int b = 0; b < 4; b++) begin
            last_mask[8*b +: 8] = {8{last_keep[b]}};
        end
    end

    rx_crc32_step u_step (
        .seed     (crc_seed),
        .data     (i_data),
        .keep     (i_data_keep),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            state          <= RX_EMPTY;
            hold_data      <= '0;
            crc_reg        <= CRC_INIT;
            err_sticky     <= 1'b0;
            o_data         <= '0;
            o_data_keep    <= '0;
            o_data_valid   <= 1'b0;
            o_data_last    <= 1'b0;
            o_status_valid <= 1'b0;
            o_crc_err      <= 1'b0;
        end else begin
            o_data_valid   <= 1'b0;
            o_data_last    <= 1'b0;
            o_status_valid <= 1'b0;
            o_crc_err      <= 1'b0;
            if (i_data_valid) begin
                if (i_data_last) begin
                    // Last beat carries only FCS bytes; the held word becomes the tail
                    o_status_valid <= 1'b1;
                    crc_reg        <= CRC_INIT;
                    err_sticky     <= 1'b0;
                    state          <= RX_EMPTY;
                    if (state == RX_HELD) begin
                        o_data_valid <= 1'b1;
                        o_data_last  <= 1'b1;
                        o_data_keep  <= last_keep;
                        o_data       <= hold_data & last_mask;
                        o_crc_err    <= (crc_next != CRC_RESIDUE) | err_sticky | last_keep_bad;
                    end else begin
                        o_crc_err    <= 1'b1;
                    end
                end else begin
                    crc_reg   <= crc_next;
                    hold_data <= i_data;
                    state     <= RX_HELD;
                    if (mid_keep_bad) begin
                        err_sticky <= 1'b1;
                    end
                    if (state == RX_HELD) begin
                        o_data_valid <= 1'b1;
                        o_data_keep  <= 4'hF;
                        o_data       <= hold_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_crc32_checker.sv
// tb/tb_rx_crc32_checker.sv - self-checking bench for rx_crc32_checker against a byte-level frame model
module tb_rx_crc32_checker;

    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [31:0] i_data = '0;
    logic [3:0]  i_data_keep = '0;
    logic        i_data_valid = 1'b0;
    logic        i_data_last = 1'b0;
    logic [31:0] o_data;
    logic [3:0]  o_data_keep;
    logic        o_data_valid;
    logic        o_data_last;
    logic        o_status_valid;
    logic        o_crc_err;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } out_t;

    logic [7:0] frame[$];
    out_t       exp_w[$];
    logic       exp_s[$];
    int         checks = 0;
    int         errors = 0;

    rx_crc32_checker dut (
        .clk            (clk),
        .i_reset_n      (i_reset_n),
        .i_data         (i_data),
        .i_data_keep    (i_data_keep),
        .i_data_valid   (i_data_valid),
        .i_data_last    (i_data_last),
        .o_data         (o_data),
        .o_data_keep    (o_data_keep),
        .o_data_valid   (o_data_valid),
        .o_data_last    (o_data_last),
        .o_status_valid (o_status_valid),
        .o_crc_err      (o_crc_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] keep);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{keep[b]}};
        return m;
    endfunction

    // Standard reflected CRC-32 over the first n frame bytes, final value inverted (the FCS)
    function automatic logic [31:0] ref_fcs(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frame[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic append_fcs();
        logic [31:0] f;
        f = ref_fcs(frame.size());
        for (int b = 0; b < 4; b++) frame.push_back(f[8*b +: 8]);
    endtask

    task automatic make_frame(input int plen);
        frame.delete();
        for (int i = 0; i < plen; i++) frame.push_back(8'($urandom_range(0, 255)));
        append_fcs();
    endtask

    // Expected output: payload = frame minus trailing 4 FCS bytes, chunked into words
    task automatic expect_frame();
        int          len;
        int          plen;
        int          n;
        out_t        o;
        logic [31:0] fcs_rx;
        len = frame.size();
        if (len <= 4) begin
            exp_s.push_back(1'b1);
        end else begin
            plen   = len - 4;
            fcs_rx = {frame[len-1], frame[len-2], frame[len-3], frame[len-4]};
            for (int i = 0; i < plen; i += 4) begin
                n = (plen - i >= 4) ? 4 : plen - i;
                o.data = '0;
                o.keep = '0;
                for (int b = 0; b < n; b++) begin
                    o.data[8*b +: 8] = frame[i+b];
                    o.keep[b] = 1'b1;
                end
                o.last = (i + 4 >= plen);
                exp_w.push_back(o);
            end
            exp_s.push_back(ref_fcs(plen) != fcs_rx);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        @(negedge clk);
        i_data = d;
        i_data_keep = k;
        i_data_valid = 1'b1;
        i_data_last = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_data_valid = 1'b0;
            i_data_last = 1'b0;
            i_data = '0;
            i_data_keep = '0;
        end
    endtask

    task automatic send_frame(input bit gaps);
        logic [31:0] w;
        logic [3:0]  k;
        logic        l;
        for (int i = 0; i < frame.size(); i += 4) begin
            w = '0;
            k = '0;
            for (int b = 0; b < 4; b++) begin
                if (i + b < frame.size()) begin
                    w[8*b +: 8] = frame[i+b];
                    k[b] = 1'b1;
                end
            end
            l = (i + 4 >= frame.size());
            beat(w, k, l);
            if (!l && gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic drain(input string tag);
        idle(4);
        check_val({tag, "_data_left"}, 64'(exp_w.size()), 64'd0);
        check_val({tag, "_status_left"}, 64'(exp_s.size()), 64'd0);
        exp_w.delete();
        exp_s.delete();
    endtask

    always @(negedge clk) begin
        out_t e;
        logic s;
        if (o_data_valid) begin
            if (exp_w.size() == 0) begin
                check_val("unexpected_data", {27'd0, o_data, o_data_keep, o_data_last}, 64'd0);
            end else begin
                e = exp_w.pop_front();
                check_val("data_beat", {27'd0, o_data & byte_mask(e.keep), o_data_keep, o_data_last},
                          {27'd0, e.data, e.keep, e.last});
            end
        end
        if (o_status_valid) begin
            if (exp_s.size() == 0) begin
                check_val("unexpected_status", {63'd0, o_crc_err}, 64'hFFFF);
            end else begin
                s = exp_s.pop_front();
                check_val("crc_err", {63'd0, o_crc_err}, {63'd0, s});
            end
        end
    end

    initial begin
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          plen;

        // Reset state
        i_reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_data_valid", {63'd0, o_data_valid}, 64'd0);
        check_val("rst_status_valid", {63'd0, o_status_valid}, 64'd0);
        check_val("rst_crc_err", {63'd0, o_crc_err}, 64'd0);
        check_val("rst_data_last", {63'd0, o_data_last}, 64'd0);
        check_val("rst_data", {32'd0, o_data}, 64'd0);
        check_val("rst_data_keep", {60'd0, o_data_keep}, 64'd0);
        i_reset_n = 1'b1;
        idle(2);

        // "123456789" with its FCS, tail byte in the word before the last beat
        frame.delete();
        for (int i = 0; i < 9; i++) frame.push_back(8'(8'h31 + i));
        append_fcs();
        expect_frame();
        send_frame(1'b0);
        drain("t1");

        // Same frame with one payload bit flipped
        frame[0] = frame[0] ^ 8'h01;
        expect_frame();
        send_frame(1'b0);
        drain("t2");

        // FCS word aligned: last beat keep F
        make_frame(8);
        expect_frame();
        send_frame(1'b0);
        drain("t3");

        // Runt single beat
        frame.delete();
        frame.push_back(8'hEF);
        frame.push_back(8'hBE);
        frame.push_back(8'hAD);
        frame.push_back(8'hDE);
        expect_frame();
        send_frame(1'b0);
        drain("t4");

        // Back-to-back good frames with mid-frame idles
        make_frame(13);
        expect_frame();
        send_frame(1'b1);
        make_frame(22);
        expect_frame();
        send_frame(1'b1);
        drain("t5");

        // Reset mid-frame, then a clean frame
        beat(32'h11223344, 4'hF, 1'b0);
        @(negedge clk);
        i_data_valid = 1'b0;
        i_reset_n = 1'b0;
        @(negedge clk);
        i_reset_n = 1'b1;
        check_val("midrst_data_valid", {63'd0, o_data_valid}, 64'd0);
        check_val("midrst_status_valid", {63'd0, o_status_valid}, 64'd0);
        make_frame(10);
        expect_frame();
        send_frame(1'b0);
        drain("t6a");

        // Non-last beat with keep 7: still forwarded as a full word, frame flagged
        w0 = $urandom;
        w1 = $urandom;
        w2 = $urandom;
        exp_w.push_back('{data: w0, keep: 4'hF, last: 1'b0});
        exp_w.push_back('{data: w1, keep: 4'hF, last: 1'b1});
        exp_s.push_back(1'b1);
        beat(w0, 4'hF, 1'b0);
        beat(w1, 4'h7, 1'b0);
        beat(w2, 4'hF, 1'b1);
        drain("t6b");

        // Non-contiguous last keep: two enabled bytes means two FCS bytes in the held word
        exp_w.push_back('{data: w0 & 32'h0000FFFF, keep: 4'h3, last: 1'b1});
        exp_s.push_back(1'b1);
        beat(w0, 4'hF, 1'b0);
        beat(w1, 4'h5, 1'b1);
        make_frame(7);
        expect_frame();
        send_frame(1'b0);
        drain("t6c");

        // Randomized frames, lengths including runts, optional corruption and gaps
        for (int f = 0; f < 30; f++) begin
            plen = $urandom_range(0, 30);
            make_frame(plen);
            if ($urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, frame.size() - 1);
                frame[idx] = frame[idx] ^ (8'h01 << $urandom_range(0, 7));
            end
            expect_frame();
            send_frame(1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end
        drain("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
